halt_dump_ctrl: RTL and testbench

Synthesizable halt-detect and data-memory dump controller for the RISC-V single-cycle core. It watches the fetched instruction word and treats an all-zero word as end-of-program. On halt it freezes the core, walks the data memory from word 0 to DEPTH-1, and streams each (address, word) pair out over a valid/ready interface for a UART or log sink. It sits beside `MicroArquitectura`: it consumes the fetched instruction and data-memory read port, and feeds a downstream serializer.

---
 rtl/dump_pkg.sv | 20 ++
 rtl/halt_dump_ctrl.sv | 107 ++++++++++
 tb/tb_halt_dump_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared types and constants for the halt-detect / data-memory dump controller.
package dump_pkg;

  typedef enum logic [2:0] {
    RUN,
    ISSUE,
    WAIT,
    SEND,
    DONE
  } dump_state_t;

  localparam logic [31:0] HALT_OPCODE = 32'h0;
  localparam int          WORD_BYTES  = 4;

  // Word index to zero-extended byte address.
  function automatic logic [31:0] wordAddr(input logic [31:0] idx);
    return idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/halt_dump_ctrl.sv
// Freezes the core on an all-zero instruction, then streams every data-memory
// word out as an (address, data) pair over a valid/ready interface.
module halt_dump_ctrl
  import dump_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_done
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dump_state_t      state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [31:0]      mem_addr_q;
  logic             mem_rd_en_q;
  logic             cpu_hold_q;
  logic             dump_valid_q;
  logic [31:0]      dump_addr_q;
  logic [31:0]      dump_data_q;
  logic             dump_done_q;

  assign idx_d = idx_q + 1'b1;

  // All outputs are registered; each transition sets the values seen in the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      idx_q        <= '0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      cpu_hold_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (inst == HALT_OPCODE) begin
            state_q     <= ISSUE;
            cpu_hold_q  <= 1'b1;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= wordAddr(32'(idx_q));
          end
        end
        ISSUE, WAIT: begin
          // A combinational memory is sampled straight out of ISSUE; a registered one needs WAIT.
          if (state_q == WAIT || RD_LAT == 0) begin
            state_q      <= SEND;
            dump_data_q  <= mem_rdata;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            dump_valid_q <= 1'b1;
            dump_addr_q  <= wordAddr(32'(idx_q));
          end else begin
            state_q <= WAIT;
          end
        end
        SEND: begin
          if (dump_valid_q && dump_ready) begin
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            if (idx_q == LAST_IDX) begin
              state_q     <= DONE;
              dump_done_q <= 1'b1;
            end else begin
              idx_q       <= idx_d;
              state_q     <= ISSUE;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= wordAddr(32'(idx_d));
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign cpu_hold   = cpu_hold_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Scoreboard bench: one controller on a combinational memory, one on a registered memory.
module tb_halt_dump_ctrl;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } expWord_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] inst;

  logic [31:0] memAddr0, memRdata0, dumpAddr0, dumpData0;
  logic        memRdEn0, cpuHold0, dumpValid0, dumpDone0;
  logic [31:0] memAddr1, memRdata1, dumpAddr1, dumpData1;
  logic        memRdEn1, cpuHold1, dumpValid1, dumpDone1;

  logic [31:0] memArr [DEPTH];
  expWord_t    q0 [$];
  expWord_t    q1 [$];

  int compared   = 0;
  int mismatched = 0;

  halt_dump_ctrl #(.DEPTH(DEPTH), .RD_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .inst(inst),
    .mem_addr(memAddr0), .mem_rd_en(memRdEn0), .mem_rdata(memRdata0),
    .cpu_hold(cpuHold0), .dump_valid(dumpValid0), .dump_ready(ready),
    .dump_addr(dumpAddr0), .dump_data(dumpData0), .dump_done(dumpDone0)
  );

  halt_dump_ctrl #(.DEPTH(DEPTH), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .inst(inst),
    .mem_addr(memAddr1), .mem_rd_en(memRdEn1), .mem_rdata(memRdata1),
    .cpu_hold(cpuHold1), .dump_valid(dumpValid1), .dump_ready(ready),
    .dump_addr(dumpAddr1), .dump_data(dumpData1), .dump_done(dumpDone1)
  );

  always #5 clk = ~clk;

  assign memRdata0 = memArr[memAddr0[4:2]];

  always @(posedge clk) begin
    if (memRdEn1) memRdata1 <= memArr[memAddr1[4:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshakes are judged at the falling edge, before the rising edge that completes them.
  always @(negedge clk) begin
    if (!rst && dumpValid0 && ready) begin
      if (q0.size() == 0) begin
        checkOutput("extraWord0", {31'b0, dumpValid0}, 32'h0);
      end else begin
        expWord_t e;
        e = q0.pop_front();
        checkOutput("addr0", dumpAddr0, e.addr);
        checkOutput("data0", dumpData0, e.data);
      end
    end
    if (!rst && dumpValid1 && ready) begin
      if (q1.size() == 0) begin
        checkOutput("extraWord1", {31'b0, dumpValid1}, 32'h0);
      end else begin
        expWord_t e;
        e = q1.pop_front();
        checkOutput("addr1", dumpAddr1, e.addr);
        checkOutput("data1", dumpData1, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] instWord, input logic rdy);
    inst  = instWord;
    ready = rdy;
    tick();
  endtask

  function automatic logic [31:0] nonZero();
    return $urandom | 32'h1;
  endfunction

  task automatic pushExpected();
    for (int i = 0; i < DEPTH; i++) begin
      expWord_t e;
      e.addr = 32'(i) * 32'd4;
      e.data = 32'hA000_0000 + 32'(i);
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_hold0"}, {31'b0, cpuHold0}, 32'h0);
    checkOutput({tag, "_valid0"}, {31'b0, dumpValid0}, 32'h0);
    checkOutput({tag, "_rden0"}, {31'b0, memRdEn0}, 32'h0);
    checkOutput({tag, "_maddr0"}, memAddr0, 32'h0);
    checkOutput({tag, "_done0"}, {31'b0, dumpDone0}, 32'h0);
    checkOutput({tag, "_daddr0"}, dumpAddr0, 32'h0);
    checkOutput({tag, "_hold1"}, {31'b0, cpuHold1}, 32'h0);
    checkOutput({tag, "_valid1"}, {31'b0, dumpValid1}, 32'h0);
    checkOutput({tag, "_rden1"}, {31'b0, memRdEn1}, 32'h0);
  endtask

  task automatic resetBoth(input logic [31:0] instAtRelease);
    rst = 1'b1;
    #1;
    checkResetOutputs("reset");
    q0.delete();
    q1.delete();
    inst = instAtRelease;
    tick();
    rst = 1'b0;
  endtask

  // k counts edges since the halt edge; finishes both dumps and checks their lengths.
  task automatic finishDumps(input string tag, input int kStart, input logic [31:0] instWord);
    int k;
    k = kStart;
    while (!dumpDone0 && k < 100) begin
      applyStimulus(instWord, 1'b1);
      k++;
    end
    checkOutput({tag, "_doneEdge0"}, 32'(k), 32'd16);
    while (!dumpDone1 && k < 100) begin
      applyStimulus(instWord, 1'b1);
      k++;
    end
    checkOutput({tag, "_doneEdge1"}, 32'(k), 32'd24);
    checkOutput({tag, "_left0"}, 32'(q0.size()), 32'd0);
    checkOutput({tag, "_left1"}, 32'(q1.size()), 32'd0);
  endtask

  initial begin
    logic bad;
    int   k;
    for (int i = 0; i < DEPTH; i++) memArr[i] = 32'hA000_0000 + 32'(i);
    rst   = 1'b1;
    ready = 1'b0;
    inst  = 32'h0000_0013;
    memRdata1 = '0;
    tick();
    resetBoth(32'h0000_0013);

    // No halt: random nonzero instructions and random ready.
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(nonZero(), 1'($urandom_range(0, 1)));
      bad = bad | cpuHold0 | dumpValid0 | dumpDone0 | cpuHold1 | dumpValid1 | dumpDone1;
    end
    checkOutput("noHalt", {31'b0, bad}, 32'h0);

    // Full dump with ready high, including halt-to-valid latency.
    for (int i = 0; i < 10; i++) applyStimulus(nonZero(), 1'b1);
    pushExpected();
    applyStimulus(32'h0, 1'b1);
    checkOutput("haltHold0", {31'b0, cpuHold0}, 32'h1);
    checkOutput("haltHold1", {31'b0, cpuHold1}, 32'h1);
    checkOutput("issueRden0", {31'b0, memRdEn0}, 32'h1);
    checkOutput("issueAddr0", memAddr0, 32'h0);
    checkOutput("issueValid0", {31'b0, dumpValid0}, 32'h0);
    applyStimulus(nonZero(), 1'b1);
    checkOutput("firstValid0", {31'b0, dumpValid0}, 32'h1);
    checkOutput("waitValid1", {31'b0, dumpValid1}, 32'h0);
    checkOutput("waitRden1", {31'b0, memRdEn1}, 32'h1);
    applyStimulus(nonZero(), 1'b1);
    checkOutput("firstValid1", {31'b0, dumpValid1}, 32'h1);
    finishDumps("run1", 2, 32'h0000_0013);

    // After DONE: halts and ready are ignored.
    for (int i = 0; i < 20; i++) applyStimulus(32'h0, 1'b1);
    checkOutput("stickyDone0", {31'b0, dumpDone0}, 32'h1);
    checkOutput("stickyDone1", {31'b0, dumpDone1}, 32'h1);
    checkOutput("stickyHold0", {31'b0, cpuHold0}, 32'h1);
    checkOutput("doneValid0", {31'b0, dumpValid0}, 32'h0);

    // Backpressure on word 3.
    resetBoth(32'h0000_0013);
    pushExpected();
    applyStimulus(32'h0, 1'b1);
    k = 0;
    while (!(dumpValid0 && dumpAddr0 == 32'd12) && k < 50) begin
      applyStimulus(nonZero(), 1'b1);
      k++;
    end
    checkOutput("bpReach", dumpAddr0, 32'd12);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(nonZero(), 1'b0);
      checkOutput("bpValid", {31'b0, dumpValid0}, 32'h1);
      checkOutput("bpAddr", dumpAddr0, 32'd12);
      checkOutput("bpData", dumpData0, 32'hA000_0003);
    end
    k = 0;
    while (!(dumpDone0 && dumpDone1) && k < 100) begin
      applyStimulus(nonZero(), 1'b1);
      k++;
    end
    checkOutput("bpDone", {30'b0, dumpDone1, dumpDone0}, 32'h3);
    checkOutput("bpLeft0", 32'(q0.size()), 32'd0);
    checkOutput("bpLeft1", 32'(q1.size()), 32'd0);

    // Reset in SEND at word 4, then halt on the first edge after release.
    resetBoth(32'h0000_0013);
    pushExpected();
    applyStimulus(32'h0, 1'b1);
    k = 0;
    while (!(dumpValid0 && dumpAddr0 == 32'd16) && k < 50) begin
      applyStimulus(nonZero(), 1'b1);
      k++;
    end
    checkOutput("midReach", dumpAddr0, 32'd16);
    resetBoth(32'h0);
    pushExpected();
    applyStimulus(32'h0, 1'b1);
    checkOutput("reHaltHold0", {31'b0, cpuHold0}, 32'h1);
    checkOutput("reHaltRden0", {31'b0, memRdEn0}, 32'h1);
    checkOutput("reHaltAddr0", memAddr0, 32'h0);
    finishDumps("run2", 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
